// File: rtl/sweep_pkg.sv
// Shared constants and types for the sum-of-products sweep controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents:
//   N_VARS_DEF / N_COMB  - default input count and combination count
//   SOP_0603B_MASK       - minterm mask of F = sum m(0,1,3,5,8,9,13)
//   SETTLE_W             - width of the settle down-counter (SETTLE <= 15)
//   sweep_state_t        - controller state encoding
package sweep_pkg;

    localparam int N_VARS_DEF = 4;
    localparam int N_COMB     = 2**N_VARS_DEF;
    localparam int SETTLE_W   = 4;

    // Minterms 0,1,3,5,8,9,13 of the reference function.
    localparam logic [N_COMB-1:0] SOP_0603B_MASK = 16'h232B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that sets how long each input combination dwells.
// Latency: load takes effect at the next edge; o_zero is combinational from the count.
// Backpressure: none; decrements only while i_en is high and stops at zero.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   i_load       - load i_load_val (has priority over counting)
//   i_load_val   - reload value
//   i_en         - count enable
//   o_zero       - count is zero
module sweep_settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sop_sweep_ctrl.sv
// Sweeps all input combinations into two SoP datapaths and compares their outputs.
// Latency: start at edge 0, last sample at edge N_COMB*SETTLE, done pulse the cycle after.
// Backpressure: start accepted only in IDLE; start during a sweep is dropped, abort cancels.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, abort        - sweep request / cancel
//   x, y, w, z          - registered combination index bits (x = MSB)
//   s1, s2              - canonical / simplified datapath outputs
//   busy, done, valid   - sweep running / completion pulse / results belong to a full sweep
//   mask_a, mask_b      - minterm masks of s1 / s2
//   mm_cnt              - mismatch count
//   first_mm(_vld)      - lowest mismatching index and its flag
//   equal               - valid sweep with no mismatches
module sop_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int N_VARS = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   x,
    output logic                   y,
    output logic                   w,
    output logic                   z,
    input  logic                   s1,
    input  logic                   s2,
    output logic                   busy,
    output logic                   done,
    output logic                   valid,
    output logic [2**N_VARS-1:0]   mask_a,
    output logic [2**N_VARS-1:0]   mask_b,
    output logic [N_VARS:0]        mm_cnt,
    output logic [N_VARS-1:0]      first_mm,
    output logic                   first_mm_vld,
    output logic                   equal
);

    localparam int                  NC        = 2**N_VARS;
    localparam logic [N_VARS-1:0]   LAST_IDX  = N_VARS'(NC - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE - 1);

    sweep_state_t        r_state;
    sweep_state_t        w_state_nxt;
    logic                w_accept;
    logic                w_sample;
    logic                w_advance;
    logic                w_finish;
    logic                w_zero;

    logic [N_VARS-1:0]   r_idx;
    logic [NC-1:0]       r_mask_a;
    logic [NC-1:0]       r_mask_b;
    logic [N_VARS:0]     r_mm_cnt;
    logic [N_VARS-1:0]   r_first_mm;
    logic                r_first_mm_vld;
    logic                r_valid;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                // abort beats a simultaneous start
                if (start && !abort) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_zero) begin
                    w_sample = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_finish    = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Dwell timer: reloaded whenever a new combination is driven
    // ------------------------------------------------------------------
    sweep_settle_timer #(
        .W (SETTLE_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept | w_advance),
        .i_load_val (SETTLE_LD),
        .i_en       (r_state == WAIT),
        .o_zero     (w_zero)
    );

    // ------------------------------------------------------------------
    // Index, masks and mismatch accounting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx          <= '0;
            r_mask_a       <= '0;
            r_mask_b       <= '0;
            r_mm_cnt       <= '0;
            r_first_mm     <= '0;
            r_first_mm_vld <= 1'b0;
            r_valid        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx          <= '0;
                r_mask_a       <= '0;
                r_mask_b       <= '0;
                r_mm_cnt       <= '0;
                r_first_mm     <= '0;
                r_first_mm_vld <= 1'b0;
                r_valid        <= 1'b0;
            end
            if (w_sample) begin
                r_mask_a[r_idx] <= s1;
                r_mask_b[r_idx] <= s2;
                // at most NC mismatches, so the N_VARS+1 bit counter cannot wrap
                if (s1 != s2) begin
                    r_mm_cnt <= r_mm_cnt + (N_VARS+1)'(1);
                    if (!r_first_mm_vld) begin
                        r_first_mm     <= r_idx;
                        r_first_mm_vld <= 1'b1;
                    end
                end
            end
            if (w_advance) begin
                r_idx <= r_idx + N_VARS'(1);
            end
            // valid rises together with entry into DONE; abort leaves it low
            if (w_finish) begin
                r_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign x            = r_idx[N_VARS-1];
    assign y            = r_idx[N_VARS-2];
    assign w            = r_idx[1];
    assign z            = r_idx[0];
    assign busy         = (r_state == WAIT);
    assign done         = (r_state == DONE);
    assign valid        = r_valid;
    assign mask_a       = r_mask_a;
    assign mask_b       = r_mask_b;
    assign mm_cnt       = r_mm_cnt;
    assign first_mm     = r_first_mm;
    assign first_mm_vld = r_first_mm_vld;
    assign equal        = r_valid && (r_mm_cnt == '0);

endmodule
